// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the single-port memory arbiter.
// Imported by mem_arbiter and lat_counter.
package mem_arbiter_pkg;

   localparam int ADDR_W  = 64;
   localparam int DATA_W  = 64;
   localparam int INSTR_W = 32;
   localparam int CNT_W   = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } arb_owner_t;

   function automatic logic [ADDR_W-1:0] dw_align(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:3], 3'b000};
   endfunction

endpackage

// File: rtl/lat_counter.sv
// Loadable down-counter that times the memory latency window.
// 'last' is high while the count equals 1.
module lat_counter
   import mem_arbiter_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         last
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load)
         count_d = load_val;
      else if (en && (count_q != '0))
         count_d = count_q - W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count = count_q;
   assign last  = (count_q == W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store onto one 64-bit memory port.
// Define ARB_RR_EN for round-robin on contested grants; default is data-first.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int MEM_LATENCY = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               if_req,
   input  logic [ADDR_W-1:0]  if_addr,
   output logic               if_ack,
   output logic [INSTR_W-1:0] if_rdata,
   input  logic               d_req,
   input  logic               d_we,
   input  logic [ADDR_W-1:0]  d_addr,
   input  logic [DATA_W-1:0]  d_wdata,
   output logic               d_ack,
   output logic [DATA_W-1:0]  d_rdata,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [DATA_W-1:0]  mem_wdata,
   output logic               mem_wr,
   input  logic [DATA_W-1:0]  mem_rdata,
   output logic               busy,
   output logic               grant_d
);

   arb_state_t          state_q, state_d;
   arb_owner_t          owner_q, owner_d;
   arb_owner_t          winner;
   logic [ADDR_W-1:2]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                mem_wr_q, mem_wr_d;
   logic                if_ack_q, if_ack_d;
   logic                d_ack_q, d_ack_d;
   logic                busy_q, busy_d;
   logic [INSTR_W-1:0]  if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
   logic                cnt_load, cnt_en, cnt_last;
   logic [CNT_W-1:0]    unused_cnt;
   logic                unused_addr_lsbs;

`ifdef ARB_RR_EN
   arb_owner_t          fav_q, fav_d;
`endif

   assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

   lat_counter #(.W(CNT_W)) u_lat_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (CNT_W'(MEM_LATENCY)),
      .en       (cnt_en),
      .count    (unused_cnt),
      .last     (cnt_last)
   );

   always_comb begin
      winner = d_req ? OWN_D : OWN_IF;
`ifdef ARB_RR_EN
      // Only a contested grant consults the favour bit.
      if (if_req && d_req)
         winner = fav_q;
`endif
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      mem_wr_d   = 1'b0;
      if_ack_d   = 1'b0;
      d_ack_d    = 1'b0;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      cnt_load   = 1'b0;
      cnt_en     = 1'b0;
`ifdef ARB_RR_EN
      fav_d      = fav_q;
`endif
      case (state_q)
         IDLE: begin
            if (if_req || d_req) begin
               state_d  = ACCESS;
               owner_d  = winner;
               cnt_load = 1'b1;
               if (winner == OWN_D) begin
                  addr_d   = d_addr[ADDR_W-1:2];
                  we_d     = d_we;
                  wdata_d  = d_wdata;
                  mem_wr_d = d_we;
               end else begin
                  addr_d   = if_addr[ADDR_W-1:2];
                  we_d     = 1'b0;
                  wdata_d  = '0;
               end
`ifdef ARB_RR_EN
               if (if_req && d_req)
                  fav_d = (winner == OWN_D) ? OWN_IF : OWN_D;
`endif
            end
         end
         ACCESS: begin
            cnt_en = 1'b1;
            if (cnt_last) begin
               state_d = RESP;
               if (owner_q == OWN_D) begin
                  d_ack_d = 1'b1;
                  if (!we_q)
                     d_rdata_d = mem_rdata;
               end else begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         owner_q    <= OWN_IF;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         mem_wr_q   <= 1'b0;
         if_ack_q   <= 1'b0;
         d_ack_q    <= 1'b0;
         busy_q     <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         mem_wr_q   <= mem_wr_d;
         if_ack_q   <= if_ack_d;
         d_ack_q    <= d_ack_d;
         busy_q     <= busy_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

`ifdef ARB_RR_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         fav_q <= OWN_D;
      else
         fav_q <= fav_d;
   end
`endif

   assign mem_addr  = {addr_q[ADDR_W-1:3], 3'b000};
   assign mem_wdata = wdata_q;
   assign mem_wr    = mem_wr_q;
   assign if_ack    = if_ack_q;
   assign d_ack     = d_ack_q;
   assign busy      = busy_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign grant_d   = (owner_q == OWN_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed cases then random rounds,
// checked against a transaction-level model of grants, latency and memory.
module tb_mem_arbiter;

   localparam int L = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, d_req, d_we;
   logic [63:0] if_addr, d_addr, d_wdata;
   logic        if_ack, d_ack, mem_wr, busy, grant_d;
   logic [31:0] if_rdata;
   logic [63:0] d_rdata, mem_addr, mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      bit          is_d;
      logic [63:0] data;
      logic [63:0] addr;
      int          cyc;
   } exp_t;

   typedef struct {
      logic [63:0] addr;
      logic [63:0] data;
      int          cyc;
   } wr_t;

   exp_t exp_q[$];
   wr_t  wr_q[$];

   logic [63:0] mem     [logic [63:0]];
   logic [63:0] ref_mem [logic [63:0]];
   logic [63:0] last_d;
   bit          fav_d;

   mem_arbiter #(.MEM_LATENCY(L)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_ack    (if_ack),
      .if_rdata  (if_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ack     (d_ack),
      .d_rdata   (d_rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wr    (mem_wr),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .grant_d   (grant_d)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] init_word(input logic [63:0] a);
      return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
   endfunction

   function automatic logic [63:0] mem_rd(input logic [63:0] a);
      return mem.exists(a) ? mem[a] : init_word(a);
   endfunction

   function automatic logic [63:0] ref_rd(input logic [63:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   // Memory macro: write strobe sampled at the clock edge, read data settles mid-cycle.
   always @(posedge clk) if (mem_wr) mem[mem_addr] = mem_wdata;
   always @(negedge clk) mem_rdata = mem_rd(mem_addr);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT acks or strobes a write.
   always @(negedge clk) begin
      exp_t e;
      wr_t  w;
      if (rst) begin
         if (if_ack || d_ack) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_ack", {62'b0, if_ack, d_ack}, 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("ack_port_d", {63'b0, d_ack}, {63'b0, e.is_d});
               chk("ack_port_if", {63'b0, if_ack}, {63'b0, !e.is_d});
               chk("ack_cycle", 64'(cyc), 64'(e.cyc));
               chk("grant_d", {63'b0, grant_d}, {63'b0, e.is_d});
               chk("busy_at_ack", {63'b0, busy}, 64'd1);
               chk("mem_addr", mem_addr, e.addr);
               if (e.is_d) chk("d_rdata", d_rdata, e.data);
               else        chk("if_rdata", {32'b0, if_rdata}, e.data);
            end
         end
         if (mem_wr) begin
            if (wr_q.size() == 0) begin
               chk("unexpected_mem_wr", {63'b0, mem_wr}, 64'd0);
            end else begin
               w = wr_q.pop_front();
               chk("wr_cycle", 64'(cyc), 64'(w.cyc));
               chk("wr_addr", mem_addr, w.addr);
               chk("wr_data", mem_wdata, w.data);
            end
         end
      end
   end

   // Reference model: each access is granted at c0 and acks L+1 cycles later.
   task automatic predict_d(input int c0, input bit we, input logic [63:0] a, input logic [63:0] wd);
      logic [63:0] al;
      al = {a[63:3], 3'b000};
      if (we) begin
         wr_q.push_back('{al, wd, c0 + 1});
         ref_mem[al] = wd;
      end else begin
         last_d = ref_rd(al);
      end
      exp_q.push_back('{1'b1, last_d, al, c0 + L + 1});
   endtask

   task automatic predict_if(input int c0, input logic [63:0] a);
      logic [63:0] al, w;
      al = {a[63:3], 3'b000};
      w  = ref_rd(al);
      exp_q.push_back('{1'b0, {32'b0, (a[2] ? w[63:32] : w[31:0])}, al, c0 + L + 1});
   endtask

   function automatic bit contested_d_first();
      bit r;
`ifdef ARB_RR_EN
      r     = fav_d;
      fav_d = !r;
`else
      r = 1'b1;
`endif
      return r;
   endfunction

   task automatic wait_done();
      int n;
      n = 0;
      while ((if_req || d_req) && n < 2 * (L + 2) + 6) begin
         @(negedge clk);
         if (if_req && if_ack) if_req = 1'b0;
         if (d_req && d_ack)   d_req  = 1'b0;
         n++;
      end
      if (if_req || d_req) begin
         chk("ack_timeout", {62'b0, if_req, d_req}, 64'd0);
         if_req = 1'b0;
         d_req  = 1'b0;
      end
   endtask

   task automatic run_round(input bit use_if, input logic [63:0] ia, input bit use_d,
                            input bit dwe, input logic [63:0] da, input logic [63:0] dwd);
      int c0;
      @(negedge clk);
      if_addr = ia;
      d_we    = dwe;
      d_addr  = da;
      d_wdata = dwd;
      if_req  = use_if;
      d_req   = use_d;
      c0      = cyc;
      if (use_if && use_d) begin
         if (contested_d_first()) begin
            predict_d(c0, dwe, da, dwd);
            predict_if(c0 + L + 2, ia);
         end else begin
            predict_if(c0, ia);
            predict_d(c0 + L + 2, dwe, da, dwd);
         end
      end else if (use_d) begin
         predict_d(c0, dwe, da, dwd);
      end else if (use_if) begin
         predict_if(c0, ia);
      end
      wait_done();
   endtask

   function automatic logic [63:0] rand_addr();
      return {($urandom_range(0, 1) != 0) ? 32'hFFFF_0000 : 32'h0, 24'h0, 8'($urandom_range(0, 255))};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      mem[64'h100]     = 64'hAAAA_BBBB_1111_2222;
      ref_mem[64'h100] = 64'hAAAA_BBBB_1111_2222;
      last_d  = '0;
      fav_d   = 1'b1;
      rst     = 1'b0;
      if_req  = 1'b0;
      d_req   = 1'b0;
      d_we    = 1'b0;
      if_addr = '0;
      d_addr  = '0;
      d_wdata = '0;

      #3;
      chk("rst_ctrl", {59'b0, mem_wr, if_ack, d_ack, busy, grant_d}, 64'd0);
      chk("rst_if_rdata", {32'b0, if_rdata}, 64'd0);
      chk("rst_d_rdata", d_rdata, 64'd0);
      chk("rst_mem_addr", mem_addr, 64'd0);
      chk("rst_mem_wdata", mem_wdata, 64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_busy", {63'b0, busy}, 64'd0);
      end

      run_round(1'b1, 64'h104, 1'b0, 1'b0, 64'h0, 64'h0);
      run_round(1'b1, 64'h100, 1'b0, 1'b0, 64'h0, 64'h0);
      run_round(1'b0, 64'h0, 1'b1, 1'b1, 64'h23, 64'hDEAD_BEEF_CAFE_F00D);
      run_round(1'b0, 64'h0, 1'b1, 1'b0, 64'h104, 64'h0);
      run_round(1'b1, 64'h104, 1'b1, 1'b0, 64'h20, 64'h0);
      run_round(1'b1, 64'h100, 1'b1, 1'b0, 64'h100, 64'h0);

      for (int i = 0; i < 40; i++) begin
         int unsigned m, gap;
         m   = $urandom_range(1, 3);
         gap = $urandom_range(0, 2);
         repeat (gap) @(negedge clk);
         run_round(m[0], rand_addr(), m[1], 1'($urandom_range(0, 1)),
                   rand_addr(), {$urandom, $urandom});
      end

      // Reset in the first ACCESS cycle of a store, then restart with d_req held.
      @(negedge clk);
      d_we    = 1'b1;
      d_addr  = 64'h48;
      d_wdata = 64'h0BAD_F00D_1234_5678;
      d_req   = 1'b1;
      c0      = cyc;
      wr_q.push_back('{64'h48, 64'h0BAD_F00D_1234_5678, c0 + 1});
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort_mem_wr", {63'b0, mem_wr}, 64'd0);
      chk("abort_busy", {63'b0, busy}, 64'd0);
      chk("abort_mem_addr", mem_addr, 64'd0);
      last_d = '0;
      fav_d  = 1'b1;
      repeat (2) @(negedge clk);
      chk("abort_no_ack", {62'b0, if_ack, d_ack}, 64'd0);
      rst = 1'b1;
      c0  = cyc;
      predict_d(c0, 1'b1, 64'h48, 64'h0BAD_F00D_1234_5678);
      wait_done();
      run_round(1'b0, 64'h0, 1'b1, 1'b0, 64'h48, 64'h0);

      repeat (4) @(negedge clk);
      chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
      chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and access sequencer for the multicycle RISC-V core. It shares one 64-bit data memory between two requesters: the instruction-fetch path, which reads 32-bit words, and the load/store path, which reads and writes 64-bit doublewords. It serializes their accesses, waits out a fixed memory latency, and returns registered read data with a one-cycle acknowledge. The block sits between the control FSM and datapath registers on one side and the memory macro on the other.

## Interface
- MEM_LATENCY, 2, cycles from address issue to valid `mem_rdata`; legal range 1..15
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; held high until `if_ack`
- if_addr  in  64  fetch byte address; stable while `if_req` is high
- if_ack  out  1  one-cycle fetch completion pulse
- if_rdata  out  32  fetched instruction word; registered, held until the next fetch ack
- d_req  in  1  data request; held high until `d_ack`
- d_we  in  1  1 = store, 0 = load
- d_addr  in  64  data byte address
- d_wdata  in  64  store data
- d_ack  out  1  one-cycle data completion pulse
- d_rdata  out  64  load data; registered, held until the next load ack
- mem_addr  out  64  memory address, doubleword aligned
- mem_wdata  out  64  memory write data
- mem_wr  out  1  memory write strobe
- mem_rdata  in  64  memory read data
- busy  out  1  high in any state other than IDLE
- grant_d  out  1  1 = the current or last owner is the data port

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - The block samples `if_req` and `d_req` on each edge.
  - If either is high, it latches the winner's address, write flag and write data into internal registers, loads the latency counter with MEM_LATENCY, and moves to ACCESS.
- Arbitration when both requests are high: data wins by default; see Configuration.
- ACCESS:
  - `mem_addr` = {latched_addr[63:3], 3'b000}.
  - `mem_wdata` = latched write data.
  - `mem_wr` is high only in the first ACCESS cycle of a store. Fetches never write.
  - The counter decrements each cycle. When it reaches 1, the block captures `mem_rdata` into the owner's read register and moves to RESP.
  - A fetch captures `mem_rdata[63:32]` if addr[2] = 1, otherwise `mem_rdata[31:0]`.
  - A store leaves `d_rdata` unchanged.
- RESP:
  - The owner's ack is high for exactly one cycle.
  - Requests are ignored in RESP; the next state is always IDLE.
- Requester rule: `req` must be low in the cycle after its ack. A `req` still high when sampled in IDLE is treated as a new request.
- Address bits [2:0] of `d_addr` and bits [1:0] of `if_addr` are ignored; there is no misalignment trap.
- Reset (asynchronous, any state, including mid-ACCESS):
  - State goes to IDLE; counter = 0.
  - `mem_wr`, `if_ack`, `d_ack`, `busy` and `grant_d` are 0.
  - `if_rdata`, `d_rdata`, `mem_addr` and `mem_wdata` are 0.
  - The round-robin pointer is set to favour data.
  - An aborted access produces no ack.

## Timing
- Request sampled at the edge ending cycle 0.
- ACCESS occupies cycles 1..MEM_LATENCY.
- Ack is high in cycle MEM_LATENCY+1; read data is valid in that same cycle.
- Next IDLE sample is at the end of cycle MEM_LATENCY+2.
- Throughput: one access per MEM_LATENCY+2 cycles.
- `mem_wr` goes high in cycle 1 only.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- ARB_RR_EN defined: round-robin arbitration. A 1-bit last-grant register makes the port that did not win the previous contested grant win the next one when both requests are high.
- ARB_RR_EN undefined: fixed priority, data over fetch; fetch may wait indefinitely while `d_req` keeps re-asserting.
- An uncontested request is granted immediately in both modes.

## Structure
- Package `mem_arbiter_pkg` holds:
  - `arb_state_t` enum (IDLE, ACCESS, RESP)
  - `arb_owner_t` enum (OWN_IF, OWN_D)
  - `ADDR_W` = 64, `DATA_W` = 64, `INSTR_W` = 32
- One natural sub-module, `lat_counter`: a loadable down-counter with load, enable, and a `last` flag asserted when the count is 1.

## Test plan
- Reset: with `rst` low, every output is 0. After release with no requests, `busy` stays 0 for 10 cycles.
- Fetch read, MEM_LATENCY=2: `if_addr`=0x104, `mem_rdata`=0xAAAABBBB11112222 -> `mem_addr`=0x100 in cycles 1–2, `if_ack` in cycle 3, `if_rdata`=0xAAAABBBB. With `if_addr`=0x100 instead -> `if_rdata`=0x11112222.
- Store: `d_we`=1, `d_addr`=0x23, `d_wdata`=0xDEADBEEFCAFEF00D -> `mem_wr` high in cycle 1 only, `mem_addr`=0x20, `d_ack` in cycle 3, `d_rdata` unchanged.
- Contention, both requests in cycle 0, ARB_RR_EN undefined -> `d_ack` in cycle 3, `if_ack` in cycle 7. Repeat contention -> data again first.
- Contention with ARB_RR_EN defined, two back-to-back contested rounds -> data first, then fetch first in the second round.
- Reset during ACCESS (cycle 1 of a store) -> `mem_wr` drops immediately and no ack occurs. After release with `d_req` held -> a full MEM_LATENCY access restarts and `d_ack` arrives 3 cycles after the first sample.
